tqvp_trng_uart_tx: RTL and testbench

Serial output stage for the TRNG peripheral. It accepts packed random bytes from the byte packager through a one-cycle `byte_valid` strobe and buffers them in a small FIFO. It then transmits them LSB-first as 8N1 UART frames on the output PMOD. Software on TinyQV programs the baud divider, gates transmission and reads status through the standard peripheral register port.

---
 rtl/tqvp_trng_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_tqvp_trng_uart_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_trng_uart_tx.sv
// TRNG serial output stage: a small byte FIFO feeding an 8N1, LSB-first UART
// transmitter, with a TinyQV register port for enable, baud divider and status.
module tqvp_trng_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_RESET  = 556
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       uart_tx,
  output logic       busy,
  output logic [1:0] state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic          en;
  logic          ovf;
  logic [15:0]   div;
  logic [15:0]   div_eff;
  logic [15:0]   divl;
  logic [15:0]   timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          timer_zero;

  // byte_valid is a one-cycle strobe with no back-pressure: the byte is taken
  // when the FIFO has room (or frees a slot by popping in the same cycle);
  // otherwise it is dropped and OVF latches.
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = byte_valid && (!full || pop);
  assign timer_zero = (timer == '0);
  assign div_eff    = (div == '0) ? 16'd1 : div;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (timer_zero) state_next = DATA;
      end
      DATA: begin
        if (timer_zero && (bit_idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        // Chain straight into the next frame so back-to-back frames have no gap.
        if (timer_zero) begin
          if (en && !empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      divl    <= 16'd1;
      uart_tx <= 1'b1;
    end else begin
      state <= state_next;
      if (pop) begin
        shift   <= mem[rd_ptr];
        divl    <= div_eff;
        timer   <= div_eff - 16'd1;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        if (timer_zero) begin
          timer <= divl - 16'd1;
          if (state == DATA) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          timer <= timer - 16'd1;
        end
      end
      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shift[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      en     <= 1'b0;
      div    <= 16'(DIV_RESET);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (data_write) begin
        case (address)
          4'h0: begin
            en <= data_in[0];
            if (data_in[1]) ovf <= 1'b0;
          end
          4'h1:    div[7:0]  <= data_in;
          4'h2:    div[15:8] <= data_in;
          default: ;
        endcase
      end
      // A drop in the same cycle as a clear leaves OVF set.
      if (byte_valid && full && !pop) ovf <= 1'b1;
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = {7'b0, en};
      4'h1:    data_out = div[7:0];
      4'h2:    data_out = div[15:8];
      4'h3:    data_out = {5'b0, ovf, full, busy};
      4'h4:    data_out[CW-1:0] = count;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tqvp_trng_uart_tx.sv
// Bench for tqvp_trng_uart_tx: register table, UART frame decoder with an
// expected-byte queue, and hand-written latency/overflow/reset sequences.
module tb_tqvp_trng_uart_tx;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_RESET  = 556;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic [3:0] address = '0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       uart_tx;
  logic       busy;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int mon_div = 4;
  bit mon_en  = 1'b1;

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[14];

  tqvp_trng_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(DIV_RESET)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_b(input logic [7:0] b, input bit expect_tx);
    @(negedge clk);
    data_write = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    byte_valid = 1'b0;
    address    = a;
    data_in    = d;
    data_write = 1'b1;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    byte_valid = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
    address = a;
    #1;
    check(name, {24'b0, data_out}, {24'b0, exp});
  endtask

  // Counts negedges with busy high until busy falls, bounded by max_cyc.
  task automatic run_busy(input int max_cyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  task automatic drain(input string name);
    repeat (3) idle_cyc();
    check(name, exp_q.size(), 0);
  endtask

  // Frame decoder: detects the start bit, samples every clock of every bit.
  initial begin : monitor
    logic [9:0] bits;
    logic       glitch;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        glitch = 1'b0;
        bits   = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < mon_div; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) glitch = 1'b1;
          end
        end
        check("frame_start_bit", {31'b0, bits[0]}, 32'd0);
        check("frame_stop_bit", {31'b0, bits[9]}, 32'd1);
        check("frame_bit_width", {31'b0, glitch}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected: got 0x%0h want no frame", bits[8:1]);
        end else begin
          want = exp_q.pop_front();
          check("frame_data", {24'b0, bits[8:1]}, {24'b0, want});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want test end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int cnt;
    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'h1, 8'h00, 8'h2C};
    vecs[2]  = '{1'b0, 4'h2, 8'h00, 8'h02};
    vecs[3]  = '{1'b0, 4'h3, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 4'h4, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 4'h7, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 4'h1, 8'h34, 8'h34};
    vecs[8]  = '{1'b1, 4'h2, 8'h12, 8'h12};
    vecs[9]  = '{1'b1, 4'h0, 8'h03, 8'h01};
    vecs[10] = '{1'b1, 4'h0, 8'h02, 8'h00};
    vecs[11] = '{1'b1, 4'h3, 8'hFF, 8'h00};
    vecs[12] = '{1'b1, 4'h4, 8'hFF, 8'h00};
    vecs[13] = '{1'b0, 4'h1, 8'h00, 8'h34};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_state", {30'b0, state_dbg}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        wr_reg(vecs[i].addr, vecs[i].wdata);
        idle_cyc();
      end
      check_reg($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // DIV=4, single byte 0xA5, with push-to-line latency
    mon_div = 4;
    wr_reg(4'h1, 8'h04);
    wr_reg(4'h2, 8'h00);
    wr_reg(4'h0, 8'h01);
    idle_cyc();
    push_b(8'hA5, 1'b1);
    idle_cyc();
    check_reg("lat_level_after_push", 4'h4, 8'h01);
    check("lat_busy_after_push", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("lat_busy_at_start", {31'b0, busy}, 32'd1);
    check("lat_tx_still_high", {31'b0, uart_tx}, 32'd1);
    @(negedge clk);
    check("lat_tx_low", {31'b0, uart_tx}, 32'd0);
    run_busy(500, cnt);
    check("div4_busy_len", cnt + 2, 40);
    check_reg("div4_level_end", 4'h4, 8'h00);
    drain("div4_drain");

    // DIV=2, three consecutive pushes while enabled: contiguous frames
    mon_div = 2;
    wr_reg(4'h1, 8'h02);
    push_b(8'h00, 1'b1);
    push_b(8'hFF, 1'b1);
    push_b(8'h3C, 1'b1);
    idle_cyc();
    run_busy(500, cnt);
    check("b2b_busy_len", cnt, 58);
    drain("b2b_drain");

    // DIV=0 behaves as DIVL=1
    mon_div = 1;
    wr_reg(4'h1, 8'h00);
    push_b(8'h96, 1'b1);
    idle_cyc();
    run_busy(500, cnt);
    check("div0_busy_len", cnt, 10);
    drain("div0_drain");

    // Overflow with EN=0, then clear OVF and enable
    mon_div = 3;
    wr_reg(4'h0, 8'h00);
    wr_reg(4'h1, 8'h03);
    push_b(8'h11, 1'b1);
    push_b(8'h22, 1'b1);
    push_b(8'h33, 1'b1);
    push_b(8'h44, 1'b1);
    push_b(8'h55, 1'b0);
    push_b(8'h66, 1'b0);
    idle_cyc();
    check_reg("ovf_level", 4'h4, 8'h04);
    check_reg("ovf_status", 4'h3, 8'h06);
    check("ovf_idle", {31'b0, busy}, 32'd0);
    wr_reg(4'h0, 8'h03);
    idle_cyc();
    check_reg("ovf_cleared_status", 4'h3, 8'h02);
    run_busy(1000, cnt);
    check("ovf_busy_len", cnt, 120);
    drain("ovf_drain");

    // Full FIFO: push exactly on the pop cycle is accepted without OVF
    mon_div = 2;
    wr_reg(4'h0, 8'h00);
    wr_reg(4'h1, 8'h02);
    push_b(8'h81, 1'b1);
    push_b(8'h42, 1'b1);
    push_b(8'h24, 1'b1);
    push_b(8'h18, 1'b1);
    idle_cyc();
    check_reg("fullpop_level_before", 4'h4, 8'h04);
    wr_reg(4'h0, 8'h01);
    push_b(8'hE7, 1'b1);
    idle_cyc();
    check_reg("fullpop_level", 4'h4, 8'h04);
    check_reg("fullpop_status", 4'h3, 8'h03);
    run_busy(1000, cnt);
    check("fullpop_busy_len", cnt, 99);
    drain("fullpop_drain");

    // Reset during DATA bit 3 with one byte still queued
    mon_en = 1'b0;
    wr_reg(4'h1, 8'h04);
    push_b(8'h5A, 1'b0);
    push_b(8'h11, 1'b0);
    idle_cyc();
    repeat (16) @(negedge clk);
    check("rst_mid_state_data", {30'b0, state_dbg}, 32'd2);
    check_reg("rst_mid_level_before", 4'h4, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check_reg("rst_mid_level", 4'h4, 8'h00);
    check_reg("rst_mid_status", 4'h3, 8'h00);
    check_reg("rst_mid_div_lo", 4'h1, 8'h2C);
    check_reg("rst_mid_ctrl", 4'h0, 8'h00);
    repeat (5) idle_cyc();
    check("rst_stays_idle", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
